// File: rtl/flit_sink_monitor_pkg.sv
// Shared flit field layout, type codes and per-VC framing states for the sink monitor.
package flit_sink_monitor_pkg;

  localparam int unsigned DataWDef = 66;
  localparam int unsigned VchDef   = 2;
  localparam int unsigned CntWDef  = 32;
  localparam int unsigned TypeW    = 2;  // type field occupies the top TypeW bits of a flit

  typedef enum logic [1:0] {
    FtNone = 2'b00,
    FtHead = 2'b01,
    FtTail = 2'b10,
    FtData = 2'b11
  } flit_type_e;

  typedef enum logic {
    StIdle = 1'b0,
    StBody = 1'b1
  } vc_state_e;

  function automatic int unsigned vch_width(input int unsigned vch);
    return (vch > 1) ? $clog2(vch) : 1;
  endfunction

endpackage

// File: rtl/flit_popcount.sv
// Combinational population count of a flit payload.
module flit_popcount
  import flit_sink_monitor_pkg::*;
#(
  parameter int unsigned DATAW = DataWDef,
  localparam int unsigned PayW = DATAW - TypeW,
  localparam int unsigned PcW  = $clog2(DATAW - 1)
) (
  input  logic [PayW-1:0] payload,
  output logic [PcW-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < PayW; i++) begin
      count = count + PcW'(payload[i]);
    end
  end

endmodule

// File: rtl/flit_sink_monitor.sv
// Router output-port sink: per-VC HEAD/DATA/TAIL framing checks, packet/flit/error statistics
// and payload toggle accumulation for switching-activity estimation.
module flit_sink_monitor
  import flit_sink_monitor_pkg::*;
#(
  parameter int unsigned DATAW = DataWDef,
  parameter int unsigned VCH   = VchDef,
  parameter int unsigned CNTW  = CntWDef,
  localparam int unsigned VCHW = vch_width(VCH)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata,
  input  logic             ivalid,
  input  logic [VCHW-1:0]  ivch,
  input  logic             en,
  input  logic             clr,
  output logic             pkt_done,
  output logic [VCHW-1:0]  pkt_vch,
  output logic [CNTW-1:0]  pkt_len,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic [CNTW-1:0]  flit_cnt,
  output logic [CNTW-1:0]  tog_cnt,
  output logic [CNTW-1:0]  err_cnt,
  output logic             err_sticky
);

  localparam int unsigned PayW = DATAW - TypeW;
  localparam int unsigned PcW  = $clog2(DATAW - 1);
  localparam int unsigned SumW = CNTW + PcW;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] a);
    return (&a) ? a : a + CNTW'(1);
  endfunction

  flit_type_e      ftype;
  logic [PayW-1:0] payload;
  logic [PayW-1:0] prev_q;
  logic [PcW-1:0]  pop;
  logic [SumW-1:0] tog_sum;
  logic [CNTW-1:0] tog_next;

  vc_state_e       state_q [VCH];
  vc_state_e       state_d [VCH];
  logic [CNTW-1:0] len_q   [VCH];
  logic [CNTW-1:0] len_d   [VCH];

  logic            flit_err;
  logic            done_d;
  logic [CNTW-1:0] done_len_d;

  assign ftype   = flit_type_e'(idata[DATAW-1 -: TypeW]);
  assign payload = idata[PayW-1:0];

  // Toggles measure wire activity, so the reference payload is shared by all VCs.
  flit_popcount #(
    .DATAW(DATAW)
  ) u_popcount (
    .payload(payload ^ prev_q),
    .count  (pop)
  );

  // Widened sum so a popcount wider than the counter still saturates correctly.
  assign tog_sum  = SumW'(tog_cnt) + SumW'(pop);
  assign tog_next = (|tog_sum[SumW-1:CNTW]) ? '1 : tog_sum[CNTW-1:0];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    flit_err   = 1'b0;
    done_d     = 1'b0;
    done_len_d = '0;
    if (ivalid) begin
      for (int v = 0; v < VCH; v++) begin
        if (VCHW'(v) == ivch) begin
          case (ftype)
            FtHead: begin
              flit_err   = (state_q[v] == StBody);
              state_d[v] = StBody;
              len_d[v]   = CNTW'(1);
            end
            FtData: begin
              if (state_q[v] == StBody) len_d[v] = sat_inc(len_q[v]);
              else                      flit_err = 1'b1;
            end
            FtTail: begin
              if (state_q[v] == StBody) begin
                state_d[v] = StIdle;
                len_d[v]   = '0;
                done_d     = 1'b1;
                done_len_d = sat_inc(len_q[v]);
              end else begin
                flit_err = 1'b1;
              end
            end
            default: flit_err = 1'b1;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int v = 0; v < VCH; v++) begin
        state_q[v] <= StIdle;
        len_q[v]   <= '0;
      end
      prev_q     <= '0;
      pkt_done   <= 1'b0;
      pkt_vch    <= '0;
      pkt_len    <= '0;
      pkt_cnt    <= '0;
      flit_cnt   <= '0;
      tog_cnt    <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      pkt_done <= done_d;
      if (ivalid)  prev_q <= payload;
      if (done_d) begin
        pkt_vch <= ivch;
        pkt_len <= done_len_d;
      end
      // clr wins over any increment landing in the same cycle.
      if (clr) begin
        pkt_cnt    <= '0;
        flit_cnt   <= '0;
        tog_cnt    <= '0;
        err_cnt    <= '0;
        err_sticky <= 1'b0;
      end else if (en && ivalid) begin
        flit_cnt <= sat_inc(flit_cnt);
        tog_cnt  <= tog_next;
        if (done_d) pkt_cnt <= sat_inc(pkt_cnt);
        if (flit_err) begin
          err_cnt    <= sat_inc(err_cnt);
          err_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Randomized scoreboard bench for flit_sink_monitor with a packet-level reference model.
module tb_flit_sink_monitor;

  localparam int DW = 66;

  logic          clk = 1'b0;
  logic          rst_;
  logic [DW-1:0] idata;
  logic          ivalid;
  logic          ivch;
  logic          en;
  logic          clr;

  logic        a_done, a_vch, a_sticky;
  logic [31:0] a_len, a_pkt, a_flit, a_tog, a_err;
  logic        b_done, b_vch, b_sticky;
  logic [3:0]  b_len, b_pkt, b_flit, b_tog, b_err;

  flit_sink_monitor #(.DATAW(DW), .VCH(2), .CNTW(32)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .en(en), .clr(clr),
    .pkt_done(a_done), .pkt_vch(a_vch), .pkt_len(a_len), .pkt_cnt(a_pkt), .flit_cnt(a_flit),
    .tog_cnt(a_tog), .err_cnt(a_err), .err_sticky(a_sticky)
  );

  // Narrow-counter instance shares stimulus and exercises saturation quickly.
  flit_sink_monitor #(.DATAW(DW), .VCH(2), .CNTW(4)) dut4 (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch), .en(en), .clr(clr),
    .pkt_done(b_done), .pkt_vch(b_vch), .pkt_len(b_len), .pkt_cnt(b_pkt), .flit_cnt(b_flit),
    .tog_cnt(b_tog), .err_cnt(b_err), .err_sticky(b_sticky)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_DATA = 2'b11;

  typedef struct {
    int     due;
    int     vch;
    longint len;
  } exp_t;

  exp_t q32[$];
  exp_t q4[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          g_en  = 1'b1;
  bit          g_clr = 1'b0;
  bit          m_inpkt[2];
  longint      m_len[2];
  longint      m_pkts, m_flits, m_tog, m_errs;
  bit          m_sticky;
  logic [63:0] m_prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic model_clear();
    for (int v = 0; v < 2; v++) begin
      m_inpkt[v] = 1'b0;
      m_len[v]   = 0;
    end
    m_pkts = 0; m_flits = 0; m_tog = 0; m_errs = 0; m_sticky = 1'b0; m_prev = '0;
  endtask

  task automatic check_counters();
    chk("pkt_cnt",     a_pkt,    sat(m_pkts, 32));
    chk("flit_cnt",    a_flit,   sat(m_flits, 32));
    chk("tog_cnt",     a_tog,    sat(m_tog, 32));
    chk("err_cnt",     a_err,    sat(m_errs, 32));
    chk("err_sticky",  a_sticky, m_sticky);
    chk("pkt_cnt4",    b_pkt,    sat(m_pkts, 4));
    chk("flit_cnt4",   b_flit,   sat(m_flits, 4));
    chk("tog_cnt4",    b_tog,    sat(m_tog, 4));
    chk("err_cnt4",    b_err,    sat(m_errs, 4));
    chk("err_sticky4", b_sticky, m_sticky);
  endtask

  task automatic model_step(input bit v, input int vch, input logic [1:0] typ,
                            input logic [63:0] pay);
    bit     e = 1'b0;
    bit     d = 1'b0;
    longint t = 0;
    exp_t   x;
    if (v) begin
      case (typ)
        T_HEAD: begin e = m_inpkt[vch]; m_inpkt[vch] = 1'b1; m_len[vch] = 1; end
        T_DATA: if (m_inpkt[vch]) m_len[vch]++; else e = 1'b1;
        T_TAIL: begin
          if (m_inpkt[vch]) begin
            d = 1'b1;
            m_inpkt[vch] = 1'b0;
            x.due = cyc + 1; x.vch = vch; x.len = m_len[vch] + 1;
            q32.push_back(x);
            q4.push_back(x);
          end else begin
            e = 1'b1;
          end
        end
        default: e = 1'b1;
      endcase
      t = $countones(pay ^ m_prev);
      m_prev = pay;
    end
    if (g_clr) begin
      m_pkts = 0; m_flits = 0; m_tog = 0; m_errs = 0; m_sticky = 1'b0;
    end else if (g_en && v) begin
      m_flits++;
      m_tog += t;
      if (d) m_pkts++;
      if (e) begin m_errs++; m_sticky = 1'b1; end
    end
  endtask

  // Each call first checks the result of the previous cycle, then drives the next flit.
  task automatic send(input bit v, input int vch, input logic [1:0] typ, input logic [63:0] pay);
    @(negedge clk);
    check_counters();
    #1;
    ivalid = v;
    ivch   = vch[0];
    idata  = {typ, pay};
    en     = g_en;
    clr    = g_clr;
    model_step(v, vch, typ, pay);
  endtask

  task automatic idle();
    send(1'b0, 0, T_NONE, m_prev);
  endtask

  task automatic do_reset(input bit pre_check);
    @(negedge clk);
    if (pre_check) check_counters();
    #1;
    ivalid = 1'b0;
    clr    = 1'b0;
    rst_   = 1'b0;
    #2;
    model_clear();
    q32.delete();
    q4.delete();
    chk("rst_pkt_done", a_done, 0);
    chk("rst_pkt_vch",  a_vch,  0);
    chk("rst_pkt_len",  a_len,  0);
    chk("rst_pkt_len4", b_len,  0);
    check_counters();
    @(negedge clk);
    #1 rst_ = 1'b1;
  endtask

  // Scoreboard monitor: pkt_done pulses are matched against model-issued expectations.
  always @(negedge clk) begin
    exp_t e;
    while (q32.size() > 0 && q32[0].due < cyc) begin
      chk("pkt_done_missing", 0, 1);
      void'(q32.pop_front());
    end
    if (a_done === 1'b1) begin
      if (q32.size() == 0 || q32[0].due != cyc) begin
        chk("pkt_done_unexpected", 1, 0);
      end else begin
        e = q32.pop_front();
        chk("pkt_vch", a_vch, e.vch);
        chk("pkt_len", a_len, sat(e.len, 32));
      end
    end
    while (q4.size() > 0 && q4[0].due < cyc) begin
      chk("pkt_done4_missing", 0, 1);
      void'(q4.pop_front());
    end
    if (b_done === 1'b1) begin
      if (q4.size() == 0 || q4[0].due != cyc) begin
        chk("pkt_done4_unexpected", 1, 0);
      end else begin
        e = q4.pop_front();
        chk("pkt_vch4", b_vch, e.vch);
        chk("pkt_len4", b_len, sat(e.len, 4));
      end
    end
  end

  initial begin
    logic [63:0] pay;
    logic [1:0]  typ;
    int          r;
    rst_ = 1'b1; ivalid = 1'b0; ivch = 1'b0; idata = '0; en = 1'b1; clr = 1'b0;
    model_clear();
    do_reset(1'b0);

    // Long packet on VC0; narrow instance saturates flit/tog counters and pkt_len.
    send(1, 0, T_HEAD, 64'h0123_4567_89ab_cdef);
    for (int i = 0; i < 20; i++) send(1, 0, T_DATA, {$urandom, $urandom});
    send(1, 0, T_TAIL, 64'hdead_beef_0000_ffff);
    idle();
    chk("t1_pkt_cnt",   a_pkt,  1);
    chk("t1_flit_cnt",  a_flit, 22);
    chk("t1_err_cnt",   a_err,  0);
    chk("t1_pkt_len",   a_len,  22);
    chk("t1_flit_sat4", b_flit, 15);
    chk("t1_len_sat4",  b_len,  15);

    // Unframed DATA on VC1, then a minimal packet.
    do_reset(1'b1);
    send(1, 1, T_DATA, 64'h5);
    send(1, 1, T_HEAD, 64'h6);
    send(1, 1, T_TAIL, 64'h7);
    idle();
    chk("t2_err_cnt",    a_err,    1);
    chk("t2_err_sticky", a_sticky, 1);
    chk("t2_pkt_len",    a_len,    2);
    chk("t2_pkt_vch",    a_vch,    1);

    // Alternating all-ones / all-zeros payloads, then constant payload.
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      pay = (i % 2 == 0) ? '1 : '0;
      typ = (i == 0) ? T_HEAD : (i == 9) ? T_TAIL : T_DATA;
      send(1, 0, typ, pay);
    end
    send(1, 1, T_HEAD, 64'h0);
    send(1, 1, T_TAIL, 64'h0);
    idle();
    chk("t3_tog_cnt", a_tog, 640);

    // Interleaved packets on two VCs.
    do_reset(1'b1);
    send(1, 0, T_HEAD, 64'h1);
    send(1, 1, T_HEAD, 64'h2);
    send(1, 0, T_DATA, 64'h3);
    send(1, 1, T_TAIL, 64'h4);
    send(1, 0, T_TAIL, 64'h5);
    idle();
    chk("t4_err_cnt", a_err, 0);
    chk("t4_pkt_cnt", a_pkt, 2);

    // Reset in the middle of a packet; the orphan TAIL must be an error.
    do_reset(1'b1);
    send(1, 0, T_HEAD, 64'h10);
    send(1, 0, T_DATA, 64'h11);
    do_reset(1'b1);
    send(1, 0, T_TAIL, 64'h12);
    idle();
    chk("t5_err_cnt",  a_err, 1);
    chk("t5_pkt_cnt",  a_pkt, 0);

    // clr coinciding with a TAIL, and en=0 holding statistics while pkt_done still pulses.
    send(1, 0, T_HEAD, 64'h20);
    g_clr = 1'b1;
    send(1, 0, T_TAIL, 64'h21);
    g_clr = 1'b0;
    idle();
    chk("t6_clr_pkt_cnt", a_pkt,    0);
    chk("t6_clr_sticky",  a_sticky, 0);
    g_en = 1'b0;
    send(1, 1, T_HEAD, 64'h30);
    send(1, 1, T_TAIL, 64'h31);
    send(1, 1, T_TAIL, 64'h32);
    idle();
    chk("t6_en0_flit_cnt", a_flit, 0);
    chk("t6_en0_err_cnt",  a_err,  0);
    g_en = 1'b1;

    // Random traffic with occasional en/clr/reset.
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset(1'b1);
      end else begin
        g_en  = ($urandom_range(0, 9) != 0);
        g_clr = ($urandom_range(0, 39) == 0);
        r = $urandom_range(0, 99);
        typ = (r < 20) ? T_HEAD : (r < 70) ? T_DATA : (r < 95) ? T_TAIL : T_NONE;
        r = $urandom_range(0, 3);
        pay = (r == 0) ? m_prev : (r == 1) ? ~m_prev : {$urandom, $urandom};
        send(($urandom_range(0, 4) != 0), $urandom_range(0, 1), typ, pay);
      end
    end
    g_en  = 1'b1;
    g_clr = 1'b0;
    idle();
    idle();
    idle();
    chk("final_q32_empty", q32.size(), 0);
    chk("final_q4_empty",  q4.size(),  0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
